// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: issues one AXI4 INCR read burst per icache miss and packs
// the 32-bit beats into a 128-bit line returned with a one-cycle ret_valid pulse.
module icache_axi_rd_bridge #(
    parameter logic [3:0] ARID_VAL = 4'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [31:0]  rd_addr,
    input  logic [1:0]   rd_len,
    output logic         ret_valid,
    output logic [127:0] ret_data,
    output logic         ret_err,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);
    localparam logic [1:0] IDLE = 2'd0, AR = 2'd1, R = 2'd2, DONE = 2'd3;
    logic [1:0] state;
    logic [1:0] cnt;
    assign arid      = ARID_VAL;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arvalid   = state == AR;
    assign rready    = state == R;
    assign ret_valid = state == DONE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            araddr   <= '0;
            arlen    <= '0;
            ret_data <= '0;
            ret_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (rd_req) begin
                    state    <= AR;
                    // full lines start on a 16-byte boundary, single words on a 4-byte one
                    araddr   <= rd_addr & (rd_len == 2'd3 ? 32'hFFFF_FFF0 : 32'hFFFF_FFFC);
                    arlen    <= {6'b0, rd_len};
                    ret_data <= '0;
                    ret_err  <= 1'b0;
                    cnt      <= '0;
                end
                AR: if (arready) state <= R;
                R: if (rvalid) begin
                    ret_data[{cnt, 5'b0} +: 32] <= rdata;
                    cnt     <= cnt + 2'd1;
                    ret_err <= ret_err | (rresp != 2'b00);
                    if (rlast) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
